// File: rtl/app_mult_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier family.
package app_mult_pkg;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_state_t;

    // One radix-4 Booth digit per pair of multiplier bits.
    function automatic int num_digits(input int width_b);
        return width_b / 2;
    endfunction

endpackage

// File: rtl/app_booth_layer.sv
// Combinational radix-4 Booth partial-product layer: pp (ones-complemented for
// negative digits) plus cin, with the low APP_BITS columns optionally zeroed.
module app_booth_layer
    import app_mult_pkg::*;
#(
    parameter int WIDTH_A  = 16,
    parameter int APP_BITS = 0
) (
    input  logic signed [WIDTH_A-1:0] a,
    input  logic        [2:0]         digit_bits,
    output logic        [WIDTH_A+1:0] pp,
    output logic                      cin
);

    localparam int PW = WIDTH_A + 2;
    localparam logic [PW-1:0] KEEP_MASK = {PW{1'b1}} << APP_BITS;

    booth_digit_t       digit;
    logic signed [PW-1:0] mag;
    logic        [PW-1:0] unit;
    logic                 neg;

    always_comb begin
        unique case (digit_bits)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
    end

    // Two guard bits keep 2*a (and its negation) exact for the most negative a.
    always_comb begin
        mag  = PW'(a);
        unit = '0;
        neg  = 1'b0;
        unique case (digit)
            POS1: unit = mag;
            POS2: unit = {mag[PW-2:0], 1'b0};
            NEG1: begin
                unit = ~mag;
                neg  = 1'b1;
            end
            NEG2: begin
                unit = ~{mag[PW-2:0], 1'b0};
                neg  = 1'b1;
            end
            default: unit = '0;
        endcase
        pp  = unit & KEEP_MASK;
        cin = neg && (APP_BITS == 0);
    end

endmodule

// File: rtl/app_booth_mult_seq.sv
// Sequential signed radix-4 Booth multiplier, one digit per clock, valid/ready
// on both sides. Define APP_BOOTH_ZERO_SKIP_EN to finish early once all
// remaining Booth digits are zero.
module app_booth_mult_seq
    import app_mult_pkg::*;
#(
    parameter int WIDTH_A  = 16,
    parameter int WIDTH_B  = 16,
    parameter int APP_BITS = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [WIDTH_A-1:0]           a,
    input  logic signed [WIDTH_B-1:0]           b,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [WIDTH_A+WIDTH_B-1:0]   p,
    output logic                                busy
);

    localparam int N  = num_digits(WIDTH_B);
    localparam int PL = WIDTH_A + WIDTH_B;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    fsm_state_t                 state;
    logic signed [WIDTH_A-1:0]  a_q;
    logic        [WIDTH_B:0]    bx_q;
    logic        [PL-1:0]       acc;
    logic        [CW-1:0]       idx;

    logic        [2:0]          digit_bits;
    logic        [WIDTH_A+1:0]  pp;
    logic                       cin;
    logic        [PL-1:0]       acc_next;
    logic                       last;

    app_booth_layer #(
        .WIDTH_A  (WIDTH_A),
        .APP_BITS (APP_BITS)
    ) u_layer (
        .a          (a_q),
        .digit_bits (digit_bits),
        .pp         (pp),
        .cin        (cin)
    );

    always_comb begin
        digit_bits = 3'(bx_q >> {idx, 1'b0});
        acc_next   = acc + (PL'($signed(pp)) << {idx, 1'b0}) + (PL'(cin) << {idx, 1'b0});
    end

`ifdef APP_BOOTH_ZERO_SKIP_EN
    logic signed [WIDTH_B:0] rest;

    // Bits above the current digit all equal means every later digit is zero;
    // on the final digit the shift leaves only sign copies, so this also ends it.
    always_comb begin
        rest = ($signed(bx_q) >>> 2) >>> {idx, 1'b0};
        last = (rest == '0) || (rest == '1);
    end
`else
    always_comb begin
        last = (idx == CW'(N - 1));
    end
`endif

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            bx_q      <= '0;
            acc       <= '0;
            idx       <= '0;
            p         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        bx_q  <= {b, 1'b0};
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    idx <= idx + CW'(1);
                    if (last) begin
                        p         <= acc_next;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
